// File: rtl/dcache_port_arbiter.sv
// Two-requester arbiter in front of a single dcache port: a store-only port (wr) and a load-only port (rd).
// Stores stream one per cycle; a load holds the port through its tag and response phases.
package dcache_pkg;
  typedef struct packed {
    logic [11:0] address_index;
    logic [19:0] address_tag;
    logic [31:0] data_wdata;
    logic [3:0]  data_wuser;
    logic        data_req;
    logic        data_we;
    logic [3:0]  data_be;
    logic [1:0]  data_size;
    logic [3:0]  data_id;
    logic        kill_req;
    logic        tag_valid;
  } dcache_req_t;

  typedef struct packed {
    logic        data_gnt;
    logic        data_rvalid;
    logic [3:0]  data_rid;
    logic [31:0] data_rdata;
    logic [3:0]  data_ruser;
  } dcache_rsp_t;
endpackage

module dcache_port_arbiter
  import dcache_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  dcache_req_t wr_req_i,
  output dcache_rsp_t wr_rsp_o,
  input  dcache_req_t rd_req_i,
  output dcache_rsp_t rd_rsp_o,
  output dcache_req_t dcache_req_o,
  input  dcache_rsp_t dcache_rsp_i
);

  typedef enum logic [1:0] {IDLE, TAG, RSP} state_e;

  state_e state_q, state_d;
  logic   last_grant_q, last_grant_d;  // 0 = wr, 1 = rd
  logic   lock_q, lock_d;
  logic   lock_sel_q, lock_sel_d;
  logic   stray_q, stray_d;            // sticky: rvalid seen with no read outstanding

  logic        sel_valid;
  logic        sel;                    // 0 = wr, 1 = rd
  logic        gnt;
  dcache_req_t sel_req;

  // Once a requester is presented without a grant it keeps the port until granted.
  always_comb begin
    sel_valid = 1'b0;
    sel       = (state_q != IDLE);
    if (state_q == IDLE) begin
      if (lock_q && (lock_sel_q ? rd_req_i.data_req : wr_req_i.data_req)) begin
        sel_valid = 1'b1;
        sel       = lock_sel_q;
      end else if (wr_req_i.data_req && rd_req_i.data_req) begin
        sel_valid = 1'b1;
        sel       = ~last_grant_q;
      end else if (wr_req_i.data_req) begin
        sel_valid = 1'b1;
        sel       = 1'b0;
      end else if (rd_req_i.data_req) begin
        sel_valid = 1'b1;
        sel       = 1'b1;
      end
    end
  end

  assign sel_req = sel ? rd_req_i : wr_req_i;
  assign gnt     = dcache_rsp_i.data_gnt & sel_valid & rst_ni;

  always_comb begin
    dcache_req_o           = sel_req;
    dcache_req_o.data_req  = sel_valid & rst_ni;
    dcache_req_o.tag_valid = 1'b0;
    dcache_req_o.kill_req  = 1'b0;
    if (state_q == TAG && rst_ni) begin
      dcache_req_o.tag_valid = rd_req_i.tag_valid;
      dcache_req_o.kill_req  = rd_req_i.kill_req;
    end

    wr_rsp_o          = '0;
    rd_rsp_o          = '0;
    wr_rsp_o.data_gnt = gnt & ~sel;
    rd_rsp_o.data_gnt = gnt & sel;
    // Read data is only accepted while a read is actually outstanding.
    if (state_q == RSP && rst_ni) begin
      rd_rsp_o.data_rvalid = dcache_rsp_i.data_rvalid;
      rd_rsp_o.data_rid    = dcache_rsp_i.data_rid;
      rd_rsp_o.data_rdata  = dcache_rsp_i.data_rdata;
      rd_rsp_o.data_ruser  = dcache_rsp_i.data_ruser;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    lock_d       = 1'b0;
    lock_sel_d   = lock_sel_q;
    stray_d      = stray_q | (dcache_rsp_i.data_rvalid & (state_q != RSP));
    unique case (state_q)
      IDLE: begin
        if (sel_valid) begin
          if (gnt) begin
            last_grant_d = sel;
            if (sel) state_d = TAG;
          end else begin
            lock_d     = 1'b1;
            lock_sel_d = sel;
          end
        end
      end
      TAG:     state_d = rd_req_i.kill_req ? IDLE : RSP;
      RSP:     if (dcache_rsp_i.data_rvalid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      lock_q       <= 1'b0;
      lock_sel_q   <= 1'b0;
      stray_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      lock_q       <= lock_d;
      lock_sel_q   <= lock_sel_d;
      stray_q      <= stray_d;
    end
  end

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Bench for dcache_port_arbiter: directed stimulus pushes expected grants/responses into a
// queue; a negedge monitor pops and compares whenever the DUT presents a grant or rvalid.
module tb_dcache_port_arbiter;
  import dcache_pkg::*;

  localparam int WG = 0;
  localparam int RG = 1;
  localparam int RV = 2;

  typedef struct {
    int          kind;
    int          cyc;
    logic [3:0]  rid;
    logic [31:0] rdata;
  } exp_t;

  logic        clk;
  logic        rst_n;
  dcache_req_t wr_req, rd_req, dc_req;
  dcache_rsp_t wr_rsp, rd_rsp, dc_rsp;

  exp_t exp_q[$];
  int   cyc;
  int   errors;
  int   checks;

  dcache_port_arbiter dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .wr_req_i    (wr_req),
    .wr_rsp_o    (wr_rsp),
    .rd_req_i    (rd_req),
    .rd_rsp_o    (rd_rsp),
    .dcache_req_o(dc_req),
    .dcache_rsp_i(dc_rsp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic dcache_req_t mk(logic req, logic we, logic [11:0] idx, logic [19:0] tag,
                                     logic [31:0] wd, logic [3:0] id);
    dcache_req_t r;
    r               = '0;
    r.data_req      = req;
    r.data_we       = we;
    r.address_index = idx;
    r.address_tag   = tag;
    r.data_wdata    = wd;
    r.data_id       = id;
    r.data_be       = 4'hF;
    r.data_size     = 2'd2;
    r.tag_valid     = ~we;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end else begin
      $display("ok   %s: 0x%0h (cycle %0d)", name, act, cyc);
    end
  endtask

  task automatic push(input int kind, input logic [3:0] rid, input logic [31:0] rdata);
    exp_t e;
    e.kind  = kind;
    e.cyc   = cyc;
    e.rid   = rid;
    e.rdata = rdata;
    exp_q.push_back(e);
  endtask

  task automatic pop_cmp(input int kind, input logic [3:0] rid, input logic [31:0] rdata);
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL sb_unexpected: got event kind=%0d at cycle %0d, required none", kind, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.cyc != cyc || (kind == RV && (e.rid !== rid || e.rdata !== rdata))) begin
        errors++;
        $display("FAIL sb_event: got kind=%0d cyc=%0d rid=%0h rdata=%0h, required kind=%0d cyc=%0d rid=%0h rdata=%0h",
                 kind, cyc, rid, rdata, e.kind, e.cyc, e.rid, e.rdata);
      end else begin
        $display("ok   sb_event kind=%0d cycle %0d", kind, cyc);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_rsp.data_gnt)    pop_cmp(WG, 4'd0, 32'd0);
      if (rd_rsp.data_gnt)    pop_cmp(RG, 4'd0, 32'd0);
      if (rd_rsp.data_rvalid) pop_cmp(RV, rd_rsp.data_rid, rd_rsp.data_rdata);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    wr_req = '0;
    rd_req = '0;
    dc_rsp = '0;

    // Reset: requests and grant present, but every response must be held low.
    #3;
    wr_req = mk(1'b1, 1'b1, 12'h010, 20'h0AAAA, 32'h11111111, 4'd1);
    dc_rsp.data_gnt = 1'b1;
    #1;
    chk("rst_wr_gnt", 64'(wr_rsp.data_gnt), 64'd0);
    chk("rst_dc_req", 64'(dc_req.data_req), 64'd0);
    chk("rst_rd_rsp", 64'(rd_rsp), 64'd0);
    step();

    // Tie after reset.
    step();
    rst_n  = 1'b1;
    rd_req = mk(1'b1, 1'b0, 12'h020, 20'h0BBBB, 32'h0, 4'd2);
    push(WG, 4'd0, 32'd0);
    #1;
    chk("flag_after_rst", 64'(dut.stray_q), 64'd0);
    chk("tie_c0_idx", 64'(dc_req.address_index), 64'h010);
    chk("tie_c0_we", 64'(dc_req.data_we), 64'd1);
    step();
    push(RG, 4'd0, 32'd0);
    #1;
    chk("tie_c1_idx", 64'(dc_req.address_index), 64'h020);
    step();
    #1;
    chk("tag_data_req", 64'(dc_req.data_req), 64'd0);
    chk("tag_valid", 64'(dc_req.tag_valid), 64'd1);
    chk("tag_addr", 64'(dc_req.address_tag), 64'h0BBBB);
    step();
    chk("rsp_tag_valid", 64'(dc_req.tag_valid), 64'd0);
    step();
    dc_rsp.data_rvalid = 1'b1;
    dc_rsp.data_rid    = 4'd3;
    dc_rsp.data_rdata  = 32'hDEADBEEF;
    push(RV, 4'd3, 32'hDEADBEEF);
    step();
    dc_rsp.data_rvalid = 1'b0;
    dc_rsp.data_rid    = 4'd0;
    dc_rsp.data_rdata  = 32'd0;
    push(WG, 4'd0, 32'd0);
    step();
    push(RG, 4'd0, 32'd0);
    step();
    wr_req.data_req = 1'b0;
    rd_req.data_req = 1'b0;
    step();
    step();
    dc_rsp.data_rvalid = 1'b1;
    dc_rsp.data_rid    = 4'd7;
    dc_rsp.data_rdata  = 32'h12345678;
    push(RV, 4'd7, 32'h12345678);
    step();
    dc_rsp.data_rvalid = 1'b0;

    // Grant lock: rd presented without grant must keep the port although wr would win a tie.
    rd_req = mk(1'b1, 1'b0, 12'h030, 20'h0CCCC, 32'h0, 4'd4);
    dc_rsp.data_gnt = 1'b0;
    #1;
    chk("lock_c0_idx", 64'(dc_req.address_index), 64'h030);
    step();
    wr_req = mk(1'b1, 1'b1, 12'h040, 20'h01111, 32'h22222222, 4'd5);
    #1;
    chk("lock_c1_idx", 64'(dc_req.address_index), 64'h030);
    step();
    #1;
    chk("lock_c2_idx", 64'(dc_req.address_index), 64'h030);
    step();
    dc_rsp.data_gnt = 1'b1;
    push(RG, 4'd0, 32'd0);
    #1;
    chk("lock_c3_idx", 64'(dc_req.address_index), 64'h030);
    chk("lock_wr_gnt", 64'(wr_rsp.data_gnt), 64'd0);
    step();
    rd_req.data_req = 1'b0;
    step();
    step();
    dc_rsp.data_rvalid = 1'b1;
    dc_rsp.data_rid    = 4'd4;
    dc_rsp.data_rdata  = 32'hCAFEF00D;
    push(RV, 4'd4, 32'hCAFEF00D);
    step();
    dc_rsp.data_rvalid = 1'b0;
    push(WG, 4'd0, 32'd0);

    // Kill in TAG.
    step();
    wr_req.data_req = 1'b0;
    rd_req = mk(1'b1, 1'b0, 12'h050, 20'h0DDDD, 32'h0, 4'd6);
    push(RG, 4'd0, 32'd0);
    step();
    rd_req.data_req = 1'b0;
    rd_req.kill_req = 1'b1;
    wr_req = mk(1'b1, 1'b1, 12'h060, 20'h02222, 32'h33333333, 4'd7);
    #1;
    chk("kill_fwd", 64'(dc_req.kill_req), 64'd1);
    chk("kill_data_req", 64'(dc_req.data_req), 64'd0);
    step();
    rd_req.kill_req = 1'b0;
    push(WG, 4'd0, 32'd0);
    #1;
    chk("kill_wr_idx", 64'(dc_req.address_index), 64'h060);
    chk("idle_kill", 64'(dc_req.kill_req), 64'd0);
    step();
    wr_req.data_req = 1'b0;

    // Stray rvalid in IDLE.
    dc_rsp.data_rvalid = 1'b1;
    dc_rsp.data_rid    = 4'd9;
    #1;
    chk("stray_flag_pre", 64'(dut.stray_q), 64'd0);
    chk("stray_drop", 64'(rd_rsp.data_rvalid), 64'd0);
    step();
    dc_rsp.data_rvalid = 1'b0;
    #1;
    chk("stray_flag", 64'(dut.stray_q), 64'd1);

    // Store streaming: eight grants back to back.
    for (int i = 0; i < 8; i++) begin
      step();
      wr_req = mk(1'b1, 1'b1, 12'(12'h100 + i), 20'h03333, 32'(i), 4'd1);
      push(WG, 4'd0, 32'd0);
      #1;
      chk("stream_idx", 64'(dc_req.address_index), 64'(12'h100 + i));
    end

    // Reset mid-read.
    step();
    wr_req.data_req = 1'b0;
    rd_req = mk(1'b1, 1'b0, 12'h070, 20'h0EEEE, 32'h0, 4'd8);
    push(RG, 4'd0, 32'd0);
    step();
    rd_req.data_req = 1'b0;
    step();
    wr_req = mk(1'b1, 1'b1, 12'h080, 20'h04444, 32'h44444444, 4'd2);
    rd_req.data_req = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_wr_rsp", 64'(wr_rsp), 64'd0);
    chk("arst_rd_rsp", 64'(rd_rsp), 64'd0);
    chk("arst_dc_req", 64'(dc_req.data_req), 64'd0);
    chk("arst_state", 64'(dut.state_q), 64'd0);
    step();
    rst_n = 1'b1;
    push(WG, 4'd0, 32'd0);
    #1;
    chk("arst_tie_idx", 64'(dc_req.address_index), 64'h080);
    step();
    wr_req.data_req    = 1'b0;
    rd_req.data_req    = 1'b0;
    dc_rsp.data_rvalid = 1'b1;
    dc_rsp.data_rid    = 4'd8;
    #1;
    chk("late_rvalid_drop", 64'(rd_rsp.data_rvalid), 64'd0);
    step();
    dc_rsp.data_rvalid = 1'b0;
    #1;
    chk("late_rvalid_flag", 64'(dut.stray_q), 64'd1);
    step();
    step();

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: got %0d pending expected events, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
